uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmit path (tx FIFO write port: tx_wen/uart_din, backpressure tx_full)

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_arbiter_rr_pick.sv | 31 +++
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit-path arbiter.
package uart_pkg;

   typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;

   localparam int UART_ARB_NREQ    = 4;
   localparam int UART_ARB_DW      = 8;
   localparam int UART_ARB_TIMEOUT = 255;

   // Index reached by stepping 'step' places after 'base' in a ring of n entries.
   function automatic int rr_wrap(input int base, input int step, input int n);
      return (base + step) % n;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request after index 'last', wrapping around.
module rr_pick
   import uart_pkg::*;
#(
   parameter int NREQ = UART_ARB_NREQ,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            found,
   output logic [IW-1:0]   idx
);

   // Scan last+1, last+2, ... and keep the first hit; 'last' itself is checked last.
   always_comb begin
      int cand;
      found = 1'b0;
      idx   = {IW{1'b0}};
      cand  = 0;
      for (int k = 1; k <= NREQ; k++) begin
         cand = rr_wrap(int'(last), k, NREQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = IW'(cand);
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter sharing the UART tx FIFO write port.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ    = UART_ARB_NREQ,
   parameter int DW      = UART_ARB_DW,
   parameter int TIMEOUT = UART_ARB_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    Rst,
   input  logic [NREQ-1:0]         req_valid,
   input  logic [NREQ*DW-1:0]      req_data,
   input  logic [NREQ-1:0]         req_last,
   output logic [NREQ-1:0]         req_ready,
   input  logic                    tx_full,
   output logic                    tx_wen,
   output logic [DW-1:0]           uart_din,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy,
   output logic                    timeout_evt
);

   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

   arb_state_e    state_r, state_s;
   logic [IW-1:0] grant_id_r, grant_id_s;
   logic [IW-1:0] last_grant_r, last_grant_s;
   logic [CW-1:0] idle_cnt_r, idle_cnt_s;
   logic          timeout_evt_r, timeout_evt_s;

   logic          pick_found_s;
   logic [IW-1:0] pick_idx_s;
   logic          own_valid_s;
   logic          own_last_s;
   logic [DW-1:0] own_data_s;

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
      .req   (req_valid),
      .last  (last_grant_r),
      .found (pick_found_s),
      .idx   (pick_idx_s)
   );

   // Select the current owner's valid/last/data lanes.
   always_comb begin
      own_valid_s = 1'b0;
      own_last_s  = 1'b0;
      own_data_s  = {DW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         if (grant_id_r == IW'(i)) begin
            own_valid_s = req_valid[i];
            own_last_s  = req_last[i];
            own_data_s  = req_data[i*DW +: DW];
         end else begin
            own_valid_s = own_valid_s;
         end
      end
   end

   // Next-state logic plus the combinational FIFO-side outputs.
   always_comb begin
      state_s       = state_r;
      grant_id_s    = grant_id_r;
      last_grant_s  = last_grant_r;
      idle_cnt_s    = idle_cnt_r;
      timeout_evt_s = 1'b0;
      tx_wen        = 1'b0;
      uart_din      = {DW{1'b0}};
      req_ready     = {NREQ{1'b0}};
      case (state_r)
         ARB_IDLE: begin
            if (pick_found_s) begin
               grant_id_s = pick_idx_s;
               idle_cnt_s = {CW{1'b0}};
               state_s    = ARB_GRANT;
            end else begin
               state_s    = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            for (int i = 0; i < NREQ; i++) begin
               req_ready[i] = (grant_id_r == IW'(i)) ? ~tx_full : 1'b0;
            end
            if (own_valid_s) begin
               // A stalled-but-valid owner is not idle.
               idle_cnt_s = {CW{1'b0}};
               if (!tx_full) begin
                  tx_wen   = 1'b1;
                  uart_din = own_data_s;
                  if (own_last_s) begin
                     state_s      = ARB_IDLE;
                     last_grant_s = grant_id_r;
                  end else begin
                     state_s      = ARB_GRANT;
                  end
               end else begin
                  state_s = ARB_GRANT;
               end
            end else if (idle_cnt_r == CNT_LAST) begin
               // Owner went quiet too long: revoke and let others in.
               state_s       = ARB_IDLE;
               last_grant_s  = grant_id_r;
               timeout_evt_s = 1'b1;
               idle_cnt_s    = {CW{1'b0}};
            end else begin
               idle_cnt_s = idle_cnt_r + {{(CW-1){1'b0}}, 1'b1};
            end
         end
         default: begin
            state_s = ARB_IDLE;
         end
      endcase
   end

   // State and bookkeeping registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!Rst) begin
         state_r       <= ARB_IDLE;
         grant_id_r    <= {IW{1'b0}};
         last_grant_r  <= LAST_RST;
         idle_cnt_r    <= {CW{1'b0}};
         timeout_evt_r <= 1'b0;
      end else begin
         state_r       <= state_s;
         grant_id_r    <= grant_id_s;
         last_grant_r  <= last_grant_s;
         idle_cnt_r    <= idle_cnt_s;
         timeout_evt_r <= timeout_evt_s;
      end
   end

   assign grant_id    = grant_id_r;
   assign timeout_evt = timeout_evt_r;
   assign busy        = (state_r == ARB_GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (NREQ=4, DW=8, TIMEOUT=8) with a write scoreboard.
module tb_uart_tx_arbiter;

   localparam int NREQ = 4;
   localparam int DW   = 8;

   logic            clk = 1'b0;
   logic            Rst;
   logic [3:0]      req_valid;
   logic [31:0]     req_data;
   logic [3:0]      req_last;
   logic [3:0]      req_ready;
   logic            tx_full;
   logic            tx_wen;
   logic [7:0]      uart_din;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout_evt;

   uart_tx_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(8)) dut (
      .clk(clk), .Rst(Rst), .req_valid(req_valid), .req_data(req_data),
      .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
      .tx_wen(tx_wen), .uart_din(uart_din), .grant_id(grant_id),
      .busy(busy), .timeout_evt(timeout_evt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   logic [8:0] src_q [4][$];   // per requester {last, data}
   logic [9:0] exp_q [$];      // expected writes {owner, data}
   logic [3:0] en;

   logic       s_wen, s_busy, s_tevt;
   logic [1:0] s_gid;
   logic [3:0] s_ready;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < 4; i++) begin
         if (en[i] && src_q[i].size() > 0) begin
            req_valid[i]        = 1'b1;
            req_data[i*8 +: 8]  = src_q[i][0][7:0];
            req_last[i]         = src_q[i][0][8];
         end else begin
            req_valid[i]        = 1'b0;
            req_data[i*8 +: 8]  = 8'h00;
            req_last[i]         = 1'b0;
         end
      end
   endtask

   task automatic ld(input int id, input logic [7:0] d, input logic last);
      src_q[id].push_back({last, d});
   endtask

   task automatic ex(input logic [1:0] id, input logic [7:0] d);
      exp_q.push_back({id, d});
   endtask

   // One clock: sample at negedge, score writes, then advance requesters after the edge.
   task automatic cycle();
      logic [3:0] acc;
      logic [9:0] e;
      @(negedge clk);
      s_wen = tx_wen; s_busy = busy; s_tevt = timeout_evt; s_gid = grant_id; s_ready = req_ready;
      acc = req_valid & req_ready;
      check_val("rdy_onehot", ($countones(req_ready) <= 1) ? 32'd1 : 32'd0, 32'd1);
      if (tx_full) check_val("wen_full", {31'd0, tx_wen}, 32'd0);
      if (tx_wen) begin
         check_val("sb_avail", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_val("sb_data", {24'd0, uart_din}, {24'd0, e[7:0]});
            check_val("sb_owner", {30'd0, grant_id}, {30'd0, e[9:8]});
            check_val("sb_hs", {31'd0, acc[e[9:8]]}, 32'd1);
         end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      end
      drive();
   endtask

   initial begin
      int pulses;
      int own3 [6];
      own3 = '{0, 1, 2, 3, 0, 1};
      Rst = 1'b0; tx_full = 1'b0; en = 4'b1111;
      req_valid = 4'b0; req_data = 32'h0; req_last = 4'b0;
      for (int i = 0; i < 4; i++) ld(i, 8'hE0 + 8'(i), 1'b1);
      drive();
      @(posedge clk);
      #1;

      // Test 1: reset held with all requesters valid
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_val("t1_wen", {31'd0, s_wen}, 32'd0);
         check_val("t1_ready", {28'd0, s_ready}, 32'd0);
         check_val("t1_busy", {31'd0, s_busy}, 32'd0);
         check_val("t1_gid", {30'd0, s_gid}, 32'd0);
      end
      for (int i = 0; i < 4; i++) src_q[i].delete();
      drive();
      Rst = 1'b1;
      cycle();

      // Test 3: continuous 1-byte messages, round-robin from req 0
      ld(0, 8'h00, 1'b1); ld(0, 8'h01, 1'b1); ld(1, 8'h10, 1'b1); ld(1, 8'h11, 1'b1);
      ld(2, 8'h20, 1'b1); ld(3, 8'h30, 1'b1);
      ex(2'd0, 8'h00); ex(2'd1, 8'h10); ex(2'd2, 8'h20); ex(2'd3, 8'h30);
      ex(2'd0, 8'h01); ex(2'd1, 8'h11);
      drive();
      for (int k = 1; k <= 13; k++) begin
         cycle();
         check_val("t3_wen", {31'd0, s_wen}, (k % 2 == 0 && k <= 12) ? 32'd1 : 32'd0);
         if (k % 2 == 0 && k <= 12)
            check_val("t3_ready", {28'd0, s_ready}, 32'd1 << own3[k/2-1]);
      end

      // Test 2: req1 three-byte message
      ld(1, 8'h41, 1'b0); ld(1, 8'h42, 1'b0); ld(1, 8'h43, 1'b1);
      ex(2'd1, 8'h41); ex(2'd1, 8'h42); ex(2'd1, 8'h43);
      drive();
      cycle();
      check_val("t2_arb_wen", {31'd0, s_wen}, 32'd0);
      check_val("t2_arb_busy", {31'd0, s_busy}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check_val("t2_gid", {30'd0, s_gid}, 32'd1);
         check_val("t2_wen", {31'd0, s_wen}, 32'd1);
      end
      cycle();
      check_val("t2_busy_end", {31'd0, s_busy}, 32'd0);

      // Test 4: tx_full stall longer than TIMEOUT with valid held
      ld(2, 8'h51, 1'b0); ld(2, 8'h52, 1'b0); ld(2, 8'h53, 1'b1);
      ex(2'd2, 8'h51); ex(2'd2, 8'h52); ex(2'd2, 8'h53);
      drive();
      cycle();
      cycle();
      check_val("t4_first", {31'd0, s_wen}, 32'd1);
      tx_full = 1'b1;
      for (int k = 0; k < 12; k++) begin
         cycle();
         check_val("t4_wen", {31'd0, s_wen}, 32'd0);
         check_val("t4_ready", {28'd0, s_ready}, 32'd0);
         check_val("t4_tevt", {31'd0, s_tevt}, 32'd0);
         check_val("t4_busy", {31'd0, s_busy}, 32'd1);
      end
      tx_full = 1'b0;
      cycle();
      check_val("t4_resume", {31'd0, s_wen}, 32'd1);
      cycle();
      check_val("t4_last", {31'd0, s_wen}, 32'd1);
      cycle();
      check_val("t4_done", {31'd0, s_busy}, 32'd0);

      // Test 5: owner idles past TIMEOUT, req3 takes over
      en = 4'b0111;
      ld(0, 8'h10, 1'b0); ld(0, 8'h11, 1'b1); ld(3, 8'h33, 1'b1);
      ex(2'd0, 8'h10); ex(2'd3, 8'h33); ex(2'd0, 8'h11);
      drive();
      cycle();
      cycle();
      check_val("t5_first", {31'd0, s_wen}, 32'd1);
      en = 4'b1110;
      drive();
      pulses = 0;
      for (int k = 3; k <= 10; k++) begin
         cycle();
         if (s_tevt) pulses++;
         check_val("t5_hold_busy", {31'd0, s_busy}, 32'd1);
         check_val("t5_hold_wen", {31'd0, s_wen}, 32'd0);
      end
      cycle();
      if (s_tevt) pulses++;
      check_val("t5_tevt", {31'd0, s_tevt}, 32'd1);
      check_val("t5_bubble", {31'd0, s_busy}, 32'd0);
      cycle();
      if (s_tevt) pulses++;
      check_val("t5_gid3", {30'd0, s_gid}, 32'd3);
      check_val("t5_wen3", {31'd0, s_wen}, 32'd1);
      check_val("t5_pulses", pulses, 32'd1);
      en = 4'b1111;
      drive();
      cycle();
      cycle();
      check_val("t5_back0", {31'd0, s_wen}, 32'd1);
      cycle();

      // Test 6: reset mid-message
      ld(1, 8'h61, 1'b0); ld(1, 8'h62, 1'b0); ld(1, 8'h63, 1'b0); ld(1, 8'h64, 1'b1);
      ld(0, 8'h70, 1'b1);
      ex(2'd1, 8'h61); ex(2'd1, 8'h62); ex(2'd1, 8'h63); ex(2'd0, 8'h70); ex(2'd1, 8'h64);
      drive();
      cycle();
      cycle();
      cycle();
      Rst = 1'b0;
      cycle();
      check_val("t6_rst_cycle", {31'd0, s_wen}, 32'd1);
      Rst = 1'b1;
      cycle();
      check_val("t6_after_wen", {31'd0, s_wen}, 32'd0);
      check_val("t6_after_busy", {31'd0, s_busy}, 32'd0);
      cycle();
      check_val("t6_gid0", {30'd0, s_gid}, 32'd0);
      check_val("t6_wen0", {31'd0, s_wen}, 32'd1);
      cycle();
      cycle();
      check_val("t6_req1", {30'd0, s_gid}, 32'd1);
      cycle();

      check_val("sb_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
